// File: rtl/chargen_pkg.sv
// Shared types and active-low polarity constants for the character-generator
// burst controller.
package chargen_pkg;

   localparam logic ACT   = 1'b0;
   localparam logic INACT = 1'b1;

   localparam int BURST_W_DEF = 8;
   localparam int LVL_W_DEF   = 5;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } ctrl_state_t;

   typedef logic [BURST_W_DEF-1:0] burst_cnt_t;
   typedef logic [LVL_W_DEF-1:0]   fifo_lvl_t;

endpackage

// File: rtl/chargen_ctrl.sv
// Burst sequencer for the character generator: issues n_cs for burst_len bytes,
// throttled by FIFO occupancy, and counts the write strobes that come back.
//
// state | meaning
// IDLE  | waiting for n_start; strobes here are unexpected
// RUN   | issuing n_cs while the FIFO has headroom and bytes remain
// DRAIN | n_cs off; waiting for outstanding strobes to be counted
// DONE  | one-cycle n_done pulse, then back to IDLE
module chargen_ctrl
   import chargen_pkg::*;
#(
   parameter int BURST_W    = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = 5,
   parameter int MARGIN     = 2
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               n_start,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               n_abort,
   input  logic [LVL_W-1:0]   fifo_level,
   input  logic               n_wr_in,
   output logic               n_cs,
   output logic               n_busy,
   output logic               n_done,
   output logic [BURST_W-1:0] count,
   output logic               n_err
);

   // Highest occupancy at which one more byte may be issued; MARGIN covers
   // the bytes already in flight that the level has not yet seen.
   localparam logic [LVL_W-1:0] LVL_LIMIT = LVL_W'(FIFO_DEPTH - 1 - MARGIN);

   ctrl_state_t        state, state_d;
   logic [BURST_W-1:0] issued, issued_d;
   logic [BURST_W-1:0] len, len_d;
   logic [BURST_W-1:0] count_d;
   logic               n_cs_d, n_busy_d, n_done_d, n_err_d;
   logic               strobe;
   logic               issue_ok;

   assign strobe   = (n_wr_in == ACT);
   assign issue_ok = (n_abort == INACT) && (issued < len) && (fifo_level <= LVL_LIMIT);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         n_cs   <= INACT;
         n_busy <= INACT;
         n_done <= INACT;
         n_err  <= INACT;
         count  <= '0;
         issued <= '0;
         len    <= '0;
      end else begin
         state  <= state_d;
         n_cs   <= n_cs_d;
         n_busy <= n_busy_d;
         n_done <= n_done_d;
         n_err  <= n_err_d;
         count  <= count_d;
         issued <= issued_d;
         len    <= len_d;
      end
   end

   always_comb begin
      state_d  = state;
      issued_d = issued;
      len_d    = len;
      count_d  = count;
      n_err_d  = n_err;
      n_cs_d   = INACT;

      // A strobe is only legitimate while bytes are still owed to us.
      if (strobe) begin
         if (state != IDLE && count < issued) begin
            count_d = count + 1'b1;
         end else begin
            n_err_d = ACT;
         end
      end

      case (state)
         IDLE: begin
            if (n_start == ACT) begin
               len_d    = burst_len;
               issued_d = '0;
               count_d  = '0;
               n_err_d  = INACT;
               state_d  = (burst_len != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (n_abort == ACT) begin
               state_d = DRAIN;
            end else if (issue_ok) begin
               n_cs_d   = ACT;
               issued_d = issued + 1'b1;
               if (issued + 1'b1 == len) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // n_cs still low here means a strobe is yet to arrive.
            if (count == issued && !strobe && n_cs == INACT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      n_busy_d = (state_d == IDLE) ? INACT : ACT;
      n_done_d = (state_d == DONE) ? ACT : INACT;
   end

endmodule

// File: tb/tb_chargen_ctrl.sv
// Bench for chargen_ctrl with a one-cycle generator model and a byte FIFO model.
module tb_chargen_ctrl;
   import chargen_pkg::*;

   localparam int BURST_W    = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int LVL_W      = 5;
   localparam int MARGIN     = 2;
   localparam int LVL_LIMIT  = FIFO_DEPTH - 1 - MARGIN;

   typedef struct {
      burst_cnt_t len;
      int         abort_at;
      bit         mid_start;
      burst_cnt_t exp_count;
      int         exp_cs;
   } vec_t;

   logic       clk       = 1'b0;
   logic       n_rst     = 1'b1;
   logic       n_start   = 1'b1;
   logic       n_abort   = 1'b1;
   burst_cnt_t burst_len = '0;
   fifo_lvl_t  fifo_level = '0;
   logic       n_wr_in;
   logic       n_cs, n_busy, n_done, n_err;
   burst_cnt_t count;

   logic       gen_wr    = 1'b1;
   logic       force_wr  = 1'b0;
   logic       reader_en = 1'b1;
   logic [7:0] gen_char  = '0;
   logic [7:0] fifo_q[$];

   int   cyc = 0;
   int   lvl_at_edge = 0;
   int   cs_cnt = 0, done_cnt = 0, busy_cnt = 0;
   int   first_cs_cyc = 0, last_cs_cyc = 0, last_done_cyc = 0;
   int   max_lvl = 0, throttle_viol = 0;
   logic prev_cs = 1'b1;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t sb_q[$];
   vec_t vecs[6];

   chargen_ctrl #(
      .BURST_W   (BURST_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .LVL_W     (LVL_W),
      .MARGIN    (MARGIN)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .n_start   (n_start),
      .burst_len (burst_len),
      .n_abort   (n_abort),
      .fifo_level(fifo_level),
      .n_wr_in   (n_wr_in),
      .n_cs      (n_cs),
      .n_busy    (n_busy),
      .n_done    (n_done),
      .count     (count),
      .n_err     (n_err)
   );

   always #5 clk = ~clk;

   assign n_wr_in = gen_wr & ~force_wr;

   // Generator strobes one edge after seeing n_cs; FIFO level lands an edge later.
   always @(posedge clk) begin
      cyc++;
      lvl_at_edge = int'(fifo_level);
      gen_wr <= n_cs;
      if (!n_wr_in) begin
         fifo_q.push_back(gen_char);
         gen_char++;
      end
      if (reader_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_level <= LVL_W'(fifo_q.size());
   end

   always @(negedge clk) begin
      if (n_cs == 1'b0) begin
         cs_cnt++;
         last_cs_cyc = cyc;
         if (prev_cs) first_cs_cyc = cyc;
         if (lvl_at_edge > LVL_LIMIT) throttle_viol++;
      end
      prev_cs = n_cs;
      if (n_done == 1'b0) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
      if (n_busy == 1'b0) busy_cnt++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_burst(input vec_t v);
      int   cs_base, done_base, busy_base, req_cyc;
      bit   aborted, ms;
      vec_t e;
      aborted   = 1'b0;
      ms        = 1'b0;
      cs_base   = cs_cnt;
      done_base = done_cnt;
      busy_base = busy_cnt;
      sb_q.push_back(v);
      n_start   = 1'b0;
      burst_len = v.len;
      req_cyc   = cyc;
      step();
      n_start = 1'b1;
      for (int i = 0; i < 400 && done_cnt == done_base; i++) begin
         n_start = 1'b1;
         if (v.abort_at > 0 && !aborted && cs_cnt - cs_base == v.abort_at) begin
            n_abort = 1'b0;
            aborted = 1'b1;
         end
         if (v.mid_start && !ms && cs_cnt - cs_base == 2) begin
            n_start   = 1'b0;
            burst_len = 8'd2;
            ms        = 1'b1;
         end
         step();
      end
      n_start = 1'b1;
      n_abort = 1'b1;
      e = sb_q.pop_front();
      check("done_seen", 64'(done_cnt - done_base), 1);
      check("count", count, e.exp_count);
      check("cs_cycles", 64'(cs_cnt - cs_base), 64'(e.exp_cs));
      check("busy_span", 64'(busy_cnt - busy_base), 64'(last_done_cyc - req_cyc));
      if (e.exp_cs > 0) check("first_cs_lat", 64'(first_cs_cyc - req_cyc), 2);
      else              check("zero_len_done_lat", 64'(last_done_cyc - req_cyc), 1);
      if (e.exp_cs > 0 && e.abort_at == 0)
         check("done_after_last_cs", 64'(last_done_cyc - last_cs_cyc), 3);
      repeat (3) step();
      check("done_once", 64'(done_cnt - done_base), 1);
      check("busy_idle", n_busy, 1);
      check("err_clear", n_err, 1);
   endtask

   initial begin
      int cs_base, done_base;
      vecs[0] = '{len: 8'd5,  abort_at: 0, mid_start: 1'b0, exp_count: 8'd5,  exp_cs: 5};
      vecs[1] = '{len: 8'd1,  abort_at: 0, mid_start: 1'b0, exp_count: 8'd1,  exp_cs: 1};
      vecs[2] = '{len: 8'd6,  abort_at: 0, mid_start: 1'b1, exp_count: 8'd6,  exp_cs: 6};
      vecs[3] = '{len: 8'd20, abort_at: 7, mid_start: 1'b0, exp_count: 8'd7,  exp_cs: 7};
      vecs[4] = '{len: 8'd0,  abort_at: 0, mid_start: 1'b0, exp_count: 8'd0,  exp_cs: 0};
      vecs[5] = '{len: 8'd13, abort_at: 0, mid_start: 1'b0, exp_count: 8'd13, exp_cs: 13};

      #1 n_rst = 1'b0;
      step();
      step();
      check("rst_n_cs", n_cs, 1);
      check("rst_n_busy", n_busy, 1);
      check("rst_n_done", n_done, 1);
      check("rst_n_err", n_err, 1);
      check("rst_count", count, 0);
      n_rst = 1'b1;
      step();
      step();

      for (int i = 0; i < 6; i++) run_burst(vecs[i]);

      // FIFO fills with no reader; issue must stall with level capped at depth.
      reader_en = 1'b0;
      step();
      cs_base   = cs_cnt;
      done_base = done_cnt;
      n_start   = 1'b0;
      burst_len = 8'd40;
      step();
      n_start = 1'b1;
      repeat (40) step();
      check("thr_cs_stalled", 64'(cs_cnt - cs_base), 16);
      check("thr_level_full", fifo_level, 16);
      check("thr_cs_high", n_cs, 1);
      check("thr_no_done", 64'(done_cnt - done_base), 0);
      reader_en = 1'b1;
      for (int i = 0; i < 400 && done_cnt == done_base; i++) step();
      check("thr_done_seen", 64'(done_cnt - done_base), 1);
      check("thr_count", count, 40);
      check("thr_cs_total", 64'(cs_cnt - cs_base), 40);
      repeat (3) step();

      // Reset asserted between edges after the third issue.
      cs_base   = cs_cnt;
      n_start   = 1'b0;
      burst_len = 8'd10;
      step();
      n_start = 1'b1;
      for (int i = 0; i < 50 && cs_cnt - cs_base < 3; i++) step();
      check("mid_rst_reached", 64'(cs_cnt - cs_base), 3);
      #2 n_rst = 1'b0;
      #1;
      check("mid_rst_n_cs", n_cs, 1);
      check("mid_rst_n_busy", n_busy, 1);
      check("mid_rst_n_done", n_done, 1);
      check("mid_rst_n_err", n_err, 1);
      check("mid_rst_count", count, 0);
      repeat (3) @(posedge clk);
      step();
      n_rst = 1'b1;
      step();
      step();
      run_burst('{len: 8'd2, abort_at: 0, mid_start: 1'b0, exp_count: 8'd2, exp_cs: 2});

      // Stray strobe while idle.
      force_wr = 1'b1;
      step();
      force_wr = 1'b0;
      step();
      check("spur_err_set", n_err, 0);
      check("spur_count_hold", count, 2);
      step();
      run_burst('{len: 8'd3, abort_at: 0, mid_start: 1'b0, exp_count: 8'd3, exp_cs: 3});

      check("max_level", 64'(max_lvl <= FIFO_DEPTH), 1);
      check("throttle_violations", 64'(throttle_viol), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
      $fatal(1, "timeout");
   end

endmodule
